mips_run_ctrl: RTL and testbench

- Synthesizable run controller wrapping one mips core for self-checking simulation and FPGA bring-up.
- Replaces free-running clock/reset stimulus with a parametrised sequence: hold the core in reset for N cycles, run it, detect halt (end address or branch-to-self loop), and enforce a cycle timeout.
- Reports cycle and committed-instruction counts plus done/timeout status to the bench or a debug port.

---
 rtl/mips_sim_pkg.sv | 19 +
 rtl/mips_halt_detect.sv | 73 +++++++
 rtl/mips_run_ctrl.sv | 153 +++++++++++++++
 tb/tb_mips_run_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_sim_pkg.sv
// Shared definitions for the mips simulation run controller.
// Holds the run-controller state encoding and the default sequencing
// constants used when the controller is instantiated without overrides.
package mips_sim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_DONE,
    ST_TOUT
  } run_state_e;

  // 10 cycles of core reset is 100 ns at a 10 ns clock.
  localparam int DEF_RST_CYCLES     = 10;
  localparam int DEF_TIMEOUT_CYCLES = 10000;
  localparam int DEF_HALT_REPEAT    = 3;

endpackage

// File: rtl/mips_halt_detect.sv
// Halt detector for the run controller.
// Watches committed pcs and raises a combinational halt flag when the
// committing pc equals the end address, or when the same pc has committed
// HALT_REPEAT times in a row (a branch-to-self loop). HALT_REPEAT = 0
// turns loop detection off.
// Ports:
//   clk, reset   - clock and asynchronous active-low reset
//   clear        - wipes the pc history at the start of a new run
//   run          - controller is in RUN; history and halt only act then
//   pc, pc_valid - pc of the instruction committing this cycle
//   end_pc       - halt address
//   halt         - combinational halt indication for this cycle
module mips_halt_detect
  import mips_sim_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            run,
  input  logic [PC_W-1:0] pc,
  input  logic            pc_valid,
  input  logic [PC_W-1:0] end_pc,
  output logic            halt
);

  localparam int REP_MAX = (HALT_REPEAT > 0) ? HALT_REPEAT : 1;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_TOP = REP_W'(REP_MAX);

  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic [REP_W-1:0] rep_q, rep_d, rep_now;
  logic             same_pc;
  logic             loop_hit;

  // rep_q == 0 means "no commit seen yet this run", so the very first
  // commit counts as 1 even if its pc happens to equal the cleared last_pc.
  always_comb begin
    same_pc = (rep_q != '0) && (pc == last_pc_q);
    if (!same_pc) begin
      rep_now = REP_W'(1);
    end else if (rep_q == REP_TOP) begin
      rep_now = REP_TOP;
    end else begin
      rep_now = rep_q + REP_W'(1);
    end
    loop_hit = (HALT_REPEAT > 0) && (rep_now == REP_TOP);
    halt     = run && pc_valid && ((pc == end_pc) || loop_hit);

    last_pc_d = last_pc_q;
    rep_d     = rep_q;
    if (clear) begin
      last_pc_d = '0;
      rep_d     = '0;
    end else if (run && pc_valid) begin
      last_pc_d = pc;
      rep_d     = rep_now;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_pc_q <= '0;
      rep_q     <= '0;
    end else begin
      last_pc_q <= last_pc_d;
      rep_q     <= rep_d;
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller wrapping one mips core.
// On start it holds the core in reset for RST_CYCLES cycles, lets it run,
// and stops it on halt (end address or branch-to-self loop) or after
// TIMEOUT_CYCLES run cycles. All outputs are registered.
// Ports:
//   clk, reset          - clock and asynchronous active-low reset
//   start               - one-cycle pulse, accepted in IDLE, DONE or TOUT
//   pc, pc_valid        - committing pc from the core
//   end_pc              - halt address
//   core_reset, core_en - synchronous reset and clock enable for the core
//   cycle_cnt           - RUN cycles elapsed
//   instr_cnt           - instructions committed
//   busy, done, timeout - run status
module mips_run_ctrl
  import mips_sim_pkg::*;
#(
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int PC_W           = 32,
  parameter int CNT_W          = 32,
  parameter int HALT_REPEAT    = DEF_HALT_REPEAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  input  logic [PC_W-1:0]  end_pc,
  output logic             core_reset,
  output logic             core_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  run_state_e       state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             core_reset_q, core_reset_d;
  logic             core_en_q, core_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             start_ok;
  logic             in_run;
  logic             halt;

  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                              (state_q == ST_TOUT));
  assign in_run   = (state_q == ST_RUN);

  mips_halt_detect #(
    .PC_W        (PC_W),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_ok),
    .run      (in_run),
    .pc       (pc),
    .pc_valid (pc_valid),
    .end_pc   (end_pc),
    .halt     (halt)
  );

  // cycle_cnt only advances on edges that stay in RUN, so a run that ends
  // (by halt or timeout) leaves it at the index of its final RUN cycle.
  // Halt is checked before timeout so a halt on the last cycle wins.
  // Outputs are decoded from the next state so they stay registered.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_TOUT: begin
        if (start_ok) begin
          state_d     = ST_RESET;
          rst_cnt_d   = '0;
          cycle_cnt_d = '0;
          instr_cnt_d = '0;
        end
      end
      ST_RESET: begin
        if (rst_cnt_q == RC_LAST) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      ST_RUN: begin
        if (pc_valid && (instr_cnt_q != CNT_MAX)) begin
          instr_cnt_d = instr_cnt_q + CNT_W'(1);
        end
        if (halt) begin
          state_d = ST_DONE;
        end else if (cycle_cnt_q == TO_LAST) begin
          state_d = ST_TOUT;
        end else if (cycle_cnt_q != CNT_MAX) begin
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    core_reset_d = (state_d == ST_IDLE) || (state_d == ST_RESET);
    core_en_d    = (state_d == ST_RESET) || (state_d == ST_RUN);
    busy_d       = (state_d == ST_RESET) || (state_d == ST_RUN);
    done_d       = (state_d == ST_DONE);
    timeout_d    = (state_d == ST_TOUT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      rst_cnt_q    <= '0;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
      core_reset_q <= 1'b1;
      core_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
      core_reset_q <= core_reset_d;
      core_en_q    <= core_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign core_reset = core_reset_q;
  assign core_en    = core_en_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign instr_cnt  = instr_cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed testbench for mips_run_ctrl with RST_CYCLES=4,
// TIMEOUT_CYCLES=20, HALT_REPEAT=3 and end_pc=0x00003010.
// Inputs change 1 ns after each rising edge; outputs are checked there.
module tb_mips_run_ctrl;

  localparam int PC_W  = 32;
  localparam int CNT_W = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic [PC_W-1:0]  pc;
  logic             pc_valid;
  logic [PC_W-1:0]  end_pc;
  logic             core_reset;
  logic             core_en;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic             busy;
  logic             done;
  logic             timeout;

  int tests_run;
  int tests_failed;

  mips_run_ctrl #(
    .RST_CYCLES     (4),
    .TIMEOUT_CYCLES (20),
    .PC_W           (PC_W),
    .CNT_W          (CNT_W),
    .HALT_REPEAT    (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .end_pc     (end_pc),
    .core_reset (core_reset),
    .core_en    (core_en),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, take the rising edge, then return the
  // pulse-type inputs to idle 1 ns after that edge.
  task automatic applyStimulus(input logic s, input logic v, input logic [31:0] p);
    start    = s;
    pc_valid = v;
    pc       = p;
    @(posedge clk);
    #1;
    start    = 1'b0;
    pc_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkFlags(input string tag, input logic cr, input logic en,
                            input logic bz, input logic dn, input logic to);
    checkOutput({tag, ".core_reset"}, {31'd0, core_reset}, {31'd0, cr});
    checkOutput({tag, ".core_en"},    {31'd0, core_en},    {31'd0, en});
    checkOutput({tag, ".busy"},       {31'd0, busy},       {31'd0, bz});
    checkOutput({tag, ".done"},       {31'd0, done},       {31'd0, dn});
    checkOutput({tag, ".timeout"},    {31'd0, timeout},    {31'd0, to});
  endtask

  task automatic checkCounts(input string tag, input logic [31:0] cyc,
                             input logic [31:0] ins);
    checkOutput({tag, ".cycle_cnt"}, cycle_cnt, cyc);
    checkOutput({tag, ".instr_cnt"}, instr_cnt, ins);
  endtask

  // Pulse start, then expect exactly four cycles with core_reset high and
  // counters at zero before the controller enters RUN.
  task automatic startRun(input string tag);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkFlags({tag, ".rst0"}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkCounts({tag, ".rst0"}, 32'd0, 32'd0);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("%s.rst%0d.core_reset", tag, i), {31'd0, core_reset}, 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkFlags({tag, ".run0"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkCounts({tag, ".run0"}, 32'd0, 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    start        = 1'b0;
    pc_valid     = 1'b0;
    pc           = '0;
    end_pc       = 32'h0000_3010;
    reset        = 1'b1;
    #2 reset = 1'b0;
    #1;
    checkFlags("por", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCounts("por", 32'd0, 32'd0);

    // Release reset away from the clock edge and idle a few cycles.
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkFlags("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Run 1: straight-line program reaching end_pc, start ignored mid-run.
    startRun("run1");
    applyStimulus(1'b0, 1'b1, 32'h3000);
    applyStimulus(1'b0, 1'b1, 32'h3004);
    checkCounts("run1.c2", 32'd2, 32'd2);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkFlags("run1.start_ign", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkCounts("run1.start_ign", 32'd3, 32'd2);
    applyStimulus(1'b0, 1'b1, 32'h3008);
    applyStimulus(1'b0, 1'b1, 32'h300c);
    checkCounts("run1.c4", 32'd5, 32'd4);
    applyStimulus(1'b0, 1'b1, 32'h3010);
    checkFlags("run1.done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkCounts("run1.done", 32'd5, 32'd5);
    applyStimulus(1'b0, 1'b1, 32'h3014);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkFlags("run1.frozen", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkCounts("run1.frozen", 32'd5, 32'd5);

    // Run 2: restart from DONE, then a branch-to-self loop on 0x3004.
    startRun("run2");
    applyStimulus(1'b0, 1'b1, 32'h3000);
    applyStimulus(1'b0, 1'b1, 32'h3004);
    applyStimulus(1'b0, 1'b1, 32'h3004);
    checkFlags("run2.rep2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkCounts("run2.rep2", 32'd3, 32'd3);
    applyStimulus(1'b0, 1'b1, 32'h3004);
    checkFlags("run2.loop", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkCounts("run2.loop", 32'd3, 32'd4);

    // Run 3: interrupted repeats never halt; the run times out instead.
    startRun("run3");
    applyStimulus(1'b0, 1'b1, 32'h3004);
    applyStimulus(1'b0, 1'b1, 32'h3008);
    applyStimulus(1'b0, 1'b1, 32'h3004);
    applyStimulus(1'b0, 1'b1, 32'h3004);
    checkFlags("run3.norep", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkCounts("run3.norep", 32'd4, 32'd4);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkFlags("run3.last", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkCounts("run3.last", 32'd19, 32'd4);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkFlags("run3.tout", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkCounts("run3.tout", 32'd19, 32'd4);

    // Run 4: restart from TOUT; halt on the final cycle beats timeout.
    startRun("run4");
    for (int i = 0; i < 19; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkCounts("run4.last", 32'd19, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h3010);
    checkFlags("run4.halt_wins", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkCounts("run4.halt_wins", 32'd19, 32'd1);

    // Run 5: asynchronous reset mid-run, off the clock edge.
    startRun("run5");
    applyStimulus(1'b0, 1'b1, 32'h3000);
    applyStimulus(1'b0, 1'b1, 32'h3004);
    checkCounts("run5.pre", 32'd2, 32'd2);
    #2 reset = 1'b0;
    #1;
    checkFlags("run5.async", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCounts("run5.async", 32'd0, 32'd0);
    #3 reset = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkFlags("run5.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCounts("run5.idle", 32'd0, 32'd0);
    startRun("run6");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
